// File: rtl/otbn_rf_bignum_wipe_ctrl_pkg.sv
// Shared constants and types for the bignum WDR write-port wipe sequencer.
package otbn_rf_bignum_wipe_ctrl_pkg;

  localparam int unsigned WLEN             = 256;
  localparam int unsigned BaseWordsPerWLEN = WLEN / 32;
  localparam int unsigned ExtWLEN          = BaseWordsPerWLEN * 39;

  // Inverted SECDED(39,32) encoding of an all-zero data word; passes the
  // register file integrity check while holding no secret.
  localparam logic [38:0] SecdedInv3932ZeroWord = 39'h2A00000000;

  // Sparse encoding: every pair of states differs in at least two bits, so a
  // single upset cannot land on another legal state.
  typedef enum logic [4:0] {
    WipeIdle = 5'b01101,
    WipeRnd  = 5'b10011,
    WipeZero = 5'b00110,
    WipeDone = 5'b11000
  } otbn_wipe_state_e;

  // Full-width integrity-protected zero word written in the second pass.
  function automatic logic [ExtWLEN-1:0] wipe_zero_word_ext();
    return {BaseWordsPerWLEN{SecdedInv3932ZeroWord}};
  endfunction

endpackage

// File: rtl/otbn_rf_bignum_wipe_ctrl_onehot_enc.sv
// Binary-to-onehot encoder with enable; one output bit per instance slot.
module otbn_rf_bignum_wipe_ctrl_onehot_enc #(
  parameter int unsigned OneHotWidth = 32,
  parameter int unsigned InputWidth  = $clog2(OneHotWidth)
) (
  input  logic [InputWidth-1:0]  in_i,
  input  logic                   en_i,
  output logic [OneHotWidth-1:0] out_o
);

  for (genvar i = 0; i < OneHotWidth; i++) begin : g_bit
    assign out_o[i] = en_i & (in_i == InputWidth'(i));
  end

endmodule

// File: rtl/otbn_rf_bignum_wipe_ctrl.sv
// WDR write-port arbiter: passes the core port through when idle, otherwise
// sequences two full passes over the WDR file (URND data, then zero word).
module otbn_rf_bignum_wipe_ctrl
  import otbn_rf_bignum_wipe_ctrl_pkg::*;
#(
  parameter int unsigned NWdr  = 32,
  parameter int unsigned WdrAw = $clog2(NWdr)
) (
  input  logic               clk_i,
  input  logic               rst_i,

  input  logic               wipe_req_i,
  output logic               wipe_busy_o,
  output logic               wipe_ack_o,

  input  logic               urnd_valid_i,
  input  logic [WLEN-1:0]    urnd_data_i,
  output logic               urnd_ack_o,

  input  logic [WdrAw-1:0]   core_wr_addr_i,
  input  logic [1:0]         core_wr_en_i,
  input  logic               core_wr_commit_i,
  input  logic [WLEN-1:0]    core_wr_data_no_intg_i,
  input  logic [ExtWLEN-1:0] core_wr_data_intg_i,
  input  logic               core_wr_data_intg_sel_i,
  input  logic [NWdr-1:0]    core_rf_we_i,

  output logic [WdrAw-1:0]   rf_wr_addr_o,
  output logic [1:0]         rf_wr_en_o,
  output logic               rf_wr_commit_o,
  output logic [WLEN-1:0]    rf_wr_data_no_intg_o,
  output logic [ExtWLEN-1:0] rf_wr_data_intg_o,
  output logic               rf_wr_data_intg_sel_o,
  output logic [NWdr-1:0]    rf_we_o,

  output logic               core_wr_err_o
);

  localparam logic [WdrAw-1:0]   LastIdx    = WdrAw'(NWdr - 1);
  localparam logic [ExtWLEN-1:0] ZeroWordExt = wipe_zero_word_ext();

  otbn_wipe_state_e state_q, state_d;
  logic [WdrAw-1:0] cnt_q, cnt_d;
  logic             wipe_we;
  logic             passthru;
  logic [NWdr-1:0]  wipe_rf_we;

  // State and WDR index counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= WipeIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and write-port muxing; busy defaults apply outside IDLE.
  always_comb begin
    state_d               = state_q;
    cnt_d                 = cnt_q;
    passthru              = 1'b0;
    wipe_we               = 1'b0;
    wipe_busy_o           = 1'b1;
    wipe_ack_o            = 1'b0;
    urnd_ack_o            = 1'b0;
    core_wr_err_o         = |core_wr_en_i;
    rf_wr_addr_o          = '0;
    rf_wr_en_o            = 2'b00;
    rf_wr_commit_o        = 1'b0;
    rf_wr_data_no_intg_o  = '0;
    rf_wr_data_intg_o     = '0;
    rf_wr_data_intg_sel_o = 1'b0;

    case (state_q)
      WipeIdle: begin
        passthru              = 1'b1;
        wipe_busy_o           = 1'b0;
        core_wr_err_o         = 1'b0;
        rf_wr_addr_o          = core_wr_addr_i;
        rf_wr_en_o            = core_wr_en_i;
        rf_wr_commit_o        = core_wr_commit_i;
        rf_wr_data_no_intg_o  = core_wr_data_no_intg_i;
        rf_wr_data_intg_o     = core_wr_data_intg_i;
        rf_wr_data_intg_sel_o = core_wr_data_intg_sel_i;
        if (wipe_req_i) begin
          state_d = WipeRnd;
          cnt_d   = '0;
        end
      end
      WipeRnd: begin
        // Stall on missing URND rather than writing stale or zero data.
        if (urnd_valid_i) begin
          wipe_we              = 1'b1;
          urnd_ack_o           = 1'b1;
          rf_wr_addr_o         = cnt_q;
          rf_wr_en_o           = 2'b11;
          rf_wr_commit_o       = 1'b1;
          rf_wr_data_no_intg_o = urnd_data_i;
          cnt_d                = cnt_q + WdrAw'(1);
          if (cnt_q == LastIdx) state_d = WipeZero;
        end
      end
      WipeZero: begin
        wipe_we               = 1'b1;
        rf_wr_addr_o          = cnt_q;
        rf_wr_en_o            = 2'b11;
        rf_wr_commit_o        = 1'b1;
        rf_wr_data_intg_sel_o = 1'b1;
        rf_wr_data_intg_o     = ZeroWordExt;
        cnt_d                 = cnt_q + WdrAw'(1);
        if (cnt_q == LastIdx) state_d = WipeDone;
      end
      WipeDone: begin
        wipe_ack_o = 1'b1;
        state_d    = WipeIdle;
      end
      default: begin
        // Corrupted state: no writes, fall back to IDLE without an ack.
        state_d = WipeIdle;
        cnt_d   = '0;
      end
    endcase
  end

  otbn_rf_bignum_wipe_ctrl_onehot_enc #(
    .OneHotWidth(NWdr),
    .InputWidth (WdrAw)
  ) u_we_enc (
    .in_i (cnt_q),
    .en_i (wipe_we),
    .out_o(wipe_rf_we)
  );

  assign rf_we_o = passthru ? core_rf_we_i : wipe_rf_we;

endmodule

// File: tb/tb_otbn_rf_bignum_wipe_ctrl.sv
// Directed bench for the WDR wipe sequencer: passthrough table, full wipe,
// URND stall with core interference, reset mid-wipe and held request.
module tb_otbn_rf_bignum_wipe_ctrl;

  localparam int NW      = 32;
  localparam int StallAt = 10;
  localparam logic [311:0] ZW = {8{39'h2A00000000}};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_i, wipe_req_i, wipe_busy_o, wipe_ack_o;
  logic         urnd_valid_i, urnd_ack_o;
  logic [255:0] urnd_data_i;
  logic [4:0]   core_wr_addr_i;
  logic [1:0]   core_wr_en_i;
  logic         core_wr_commit_i, core_wr_data_intg_sel_i;
  logic [255:0] core_wr_data_no_intg_i;
  logic [311:0] core_wr_data_intg_i;
  logic [31:0]  core_rf_we_i;
  logic [4:0]   rf_wr_addr_o;
  logic [1:0]   rf_wr_en_o;
  logic         rf_wr_commit_o, rf_wr_data_intg_sel_o, core_wr_err_o;
  logic [255:0] rf_wr_data_no_intg_o;
  logic [311:0] rf_wr_data_intg_o;
  logic [31:0]  rf_we_o;

  otbn_rf_bignum_wipe_ctrl dut (
    .clk_i(clk), .rst_i(rst_i),
    .wipe_req_i(wipe_req_i), .wipe_busy_o(wipe_busy_o), .wipe_ack_o(wipe_ack_o),
    .urnd_valid_i(urnd_valid_i), .urnd_data_i(urnd_data_i), .urnd_ack_o(urnd_ack_o),
    .core_wr_addr_i(core_wr_addr_i), .core_wr_en_i(core_wr_en_i),
    .core_wr_commit_i(core_wr_commit_i), .core_wr_data_no_intg_i(core_wr_data_no_intg_i),
    .core_wr_data_intg_i(core_wr_data_intg_i), .core_wr_data_intg_sel_i(core_wr_data_intg_sel_i),
    .core_rf_we_i(core_rf_we_i),
    .rf_wr_addr_o(rf_wr_addr_o), .rf_wr_en_o(rf_wr_en_o), .rf_wr_commit_o(rf_wr_commit_o),
    .rf_wr_data_no_intg_o(rf_wr_data_no_intg_o), .rf_wr_data_intg_o(rf_wr_data_intg_o),
    .rf_wr_data_intg_sel_o(rf_wr_data_intg_sel_o), .rf_we_o(rf_we_o),
    .core_wr_err_o(core_wr_err_o)
  );

  // Register file model fed by the RF-side write port.
  logic [311:0] mem [NW];
  always @(posedge clk)
    if (!rst_i && rf_wr_commit_o && rf_wr_en_o == 2'b11)
      mem[rf_wr_addr_o] <= rf_wr_data_intg_sel_o ? rf_wr_data_intg_o : {56'd0, rf_wr_data_no_intg_o};

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [319:0] act, input logic [319:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare every port against the expected wipe-side behaviour of one cycle.
  task automatic check_cycle(input string tag, input int c, input logic eb, input logic ea,
                             input logic ew, input logic [4:0] a, input logic sel,
                             input logic ua, input logic [255:0] nd, input logic eerr);
    logic [31:0] oh;
    oh = ew ? (32'd1 << a) : 32'd0;
    chk($sformatf("%s_c%0d_busy", tag, c), 320'(wipe_busy_o), 320'(eb));
    chk($sformatf("%s_c%0d_ack", tag, c), 320'(wipe_ack_o), 320'(ea));
    chk($sformatf("%s_c%0d_urnd_ack", tag, c), 320'(urnd_ack_o), 320'(ua));
    chk($sformatf("%s_c%0d_err", tag, c), 320'(core_wr_err_o), 320'(eerr));
    chk($sformatf("%s_c%0d_en", tag, c), 320'(rf_wr_en_o), ew ? 320'd3 : 320'd0);
    chk($sformatf("%s_c%0d_commit", tag, c), 320'(rf_wr_commit_o), 320'(ew));
    chk($sformatf("%s_c%0d_we", tag, c), 320'(rf_we_o), 320'(oh));
    chk($sformatf("%s_c%0d_nointg", tag, c), 320'(rf_wr_data_no_intg_o),
        (ew && !sel) ? 320'(nd) : 320'd0);
    chk($sformatf("%s_c%0d_intg", tag, c), 320'(rf_wr_data_intg_o),
        (ew && sel) ? 320'(ZW) : 320'd0);
    if (ew) begin
      chk($sformatf("%s_c%0d_addr", tag, c), 320'(rf_wr_addr_o), 320'(a));
      chk($sformatf("%s_c%0d_sel", tag, c), 320'(rf_wr_data_intg_sel_o), 320'(sel));
    end
  endtask

  // One wipe from a request in the current IDLE cycle (cycle 0) to IDLE again.
  task automatic run_wipe(input string tag, input int stall_len, input bit hold_req,
                          input bit interfere);
    int rnd_end, done_c, last_c;
    logic wr, sel, ua, busy;
    logic [4:0] a;
    logic [255:0] nd;
    logic [1:0] cen;
    rnd_end = NW + stall_len;
    done_c  = rnd_end + NW + 1;
    last_c  = hold_req ? done_c + 2 : done_c + 1;
    core_wr_addr_i          = 5'd7;
    core_wr_en_i            = 2'b00;
    core_wr_commit_i        = 1'b1;
    core_wr_data_no_intg_i  = {8{32'hDEADBEEF}};
    core_wr_data_intg_i     = '1;
    core_wr_data_intg_sel_i = 1'b1;
    core_rf_we_i            = 32'hFFFF0000;
    urnd_valid_i            = 1'b1;
    wipe_req_i              = 1'b1;
    for (int c = 1; c <= last_c; c++) begin
      tick();
      wipe_req_i   = hold_req;
      urnd_valid_i = !(c > StallAt && c <= StallAt + stall_len);
      nd           = {8{32'(c) ^ 32'hA5A50000}};
      urnd_data_i  = nd;
      cen = 2'b00;
      if (interfere && c == 20) cen = 2'b01;
      if (interfere && c == 40) cen = 2'b11;
      core_wr_en_i = cen;
      #2;
      wr = 1'b0; sel = 1'b0; ua = 1'b0; a = '0;
      busy = (c <= done_c) || (hold_req && c == done_c + 2);
      if (c <= rnd_end) begin
        wr = urnd_valid_i;
        ua = wr;
        a  = (c <= StallAt) ? 5'(c - 1) : 5'(c - 1 - stall_len);
      end else if (c < done_c) begin
        wr = 1'b1; sel = 1'b1; a = 5'(c - rnd_end - 1);
      end else if (hold_req && c == done_c + 2) begin
        wr = 1'b1; ua = 1'b1; a = 5'd0;
      end
      if (!busy) begin
        // Idle cycle between wipes: core port visible again.
        chk($sformatf("%s_c%0d_idle_busy", tag, c), 320'(wipe_busy_o), 320'd0);
        chk($sformatf("%s_c%0d_idle_ack", tag, c), 320'(wipe_ack_o), 320'd0);
        chk($sformatf("%s_c%0d_idle_addr", tag, c), 320'(rf_wr_addr_o), 320'd7);
        chk($sformatf("%s_c%0d_idle_we", tag, c), 320'(rf_we_o), 320'h0FFFF0000);
        chk($sformatf("%s_c%0d_idle_err", tag, c), 320'(core_wr_err_o), 320'd0);
      end else begin
        check_cycle(tag, c, 1'b1, c == done_c, wr, a, sel, ua, nd, |cen);
      end
    end
    wipe_req_i = 1'b0;
  endtask

  typedef struct {
    logic [4:0]   addr;
    logic [1:0]   en;
    logic         commit;
    logic         sel;
    logic [255:0] nd;
    logic [311:0] id;
    logic [31:0]  we;
    logic [4:0]   e_addr;
    logic [1:0]   e_en;
    logic         e_commit;
    logic         e_sel;
    logic [255:0] e_nd;
    logic [311:0] e_id;
    logic [31:0]  e_we;
  } vec_t;

  vec_t vt [4];
  int   nack;
  logic bad_busy;

  initial begin
    vt[0] = '{5'd5, 2'b01, 1'b1, 1'b0, {8{32'h11112222}}, '0, 32'h00000020,
              5'd5, 2'b01, 1'b1, 1'b0, {8{32'h11112222}}, '0, 32'h00000020};
    vt[1] = '{5'd31, 2'b10, 1'b0, 1'b0, {8{32'hCAFEF00D}}, {8{39'h1234567}}, 32'h80000000,
              5'd31, 2'b10, 1'b0, 1'b0, {8{32'hCAFEF00D}}, {8{39'h1234567}}, 32'h80000000};
    vt[2] = '{5'd0, 2'b11, 1'b1, 1'b1, '0, {8{39'h7FFFFFFFFF}}, 32'h00000001,
              5'd0, 2'b11, 1'b1, 1'b1, '0, {8{39'h7FFFFFFFFF}}, 32'h00000001};
    vt[3] = '{5'd17, 2'b00, 1'b0, 1'b0, {8{32'h0F0F0F0F}}, '0, 32'h00020000,
              5'd17, 2'b00, 1'b0, 1'b0, {8{32'h0F0F0F0F}}, '0, 32'h00020000};

    rst_i = 1'b1; wipe_req_i = 1'b0; urnd_valid_i = 1'b0; urnd_data_i = '0;
    core_wr_addr_i = '0; core_wr_en_i = '0; core_wr_commit_i = 1'b0;
    core_wr_data_no_intg_i = '0; core_wr_data_intg_i = '0; core_wr_data_intg_sel_i = 1'b0;
    core_rf_we_i = '0;
    tick(); tick();
    rst_i = 1'b0;
    #2;
    chk("rst_busy", 320'(wipe_busy_o), 320'd0);
    chk("rst_ack", 320'(wipe_ack_o), 320'd0);
    chk("rst_urnd_ack", 320'(urnd_ack_o), 320'd0);
    chk("rst_err", 320'(core_wr_err_o), 320'd0);

    // Passthrough table in IDLE; outputs must follow within the same cycle.
    for (int i = 0; i < 4; i++) begin
      tick();
      core_wr_addr_i = vt[i].addr; core_wr_en_i = vt[i].en; core_wr_commit_i = vt[i].commit;
      core_wr_data_intg_sel_i = vt[i].sel; core_wr_data_no_intg_i = vt[i].nd;
      core_wr_data_intg_i = vt[i].id; core_rf_we_i = vt[i].we;
      #2;
      chk($sformatf("pt%0d_addr", i), 320'(rf_wr_addr_o), 320'(vt[i].e_addr));
      chk($sformatf("pt%0d_en", i), 320'(rf_wr_en_o), 320'(vt[i].e_en));
      chk($sformatf("pt%0d_commit", i), 320'(rf_wr_commit_o), 320'(vt[i].e_commit));
      chk($sformatf("pt%0d_sel", i), 320'(rf_wr_data_intg_sel_o), 320'(vt[i].e_sel));
      chk($sformatf("pt%0d_nointg", i), 320'(rf_wr_data_no_intg_o), 320'(vt[i].e_nd));
      chk($sformatf("pt%0d_intg", i), 320'(rf_wr_data_intg_o), 320'(vt[i].e_id));
      chk($sformatf("pt%0d_we", i), 320'(rf_we_o), 320'(vt[i].e_we));
      chk($sformatf("pt%0d_err", i), 320'(core_wr_err_o), 320'd0);
      chk($sformatf("pt%0d_busy", i), 320'(wipe_busy_o), 320'd0);
    end

    // Full wipe, URND always valid: ack in cycle 65.
    tick();
    run_wipe("full", 0, 1'b0, 1'b0);
    for (int i = 0; i < NW; i++)
      chk($sformatf("sb_mem%0d", i), 320'(mem[i]), 320'(ZW));

    // URND stalled 3 cycles at counter 10, core pokes in RND and ZERO: ack in cycle 68.
    run_wipe("stall", 3, 1'b0, 1'b1);

    // Reset in RND with counter 20.
    wipe_req_i = 1'b1; urnd_valid_i = 1'b1; core_wr_en_i = 2'b00;
    for (int c = 1; c <= 21; c++) begin
      tick();
      wipe_req_i = 1'b0;
    end
    #2;
    chk("rstmid_addr20", 320'(rf_wr_addr_o), 320'd20);
    chk("rstmid_busy_pre", 320'(wipe_busy_o), 320'd1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    core_wr_addr_i = 5'd9; core_wr_en_i = 2'b10; core_wr_commit_i = 1'b1;
    core_wr_data_intg_sel_i = 1'b0; core_wr_data_no_intg_i = {8{32'h01234567}};
    core_rf_we_i = 32'h00000200;
    #2;
    chk("rstmid_busy", 320'(wipe_busy_o), 320'd0);
    chk("rstmid_pt_addr", 320'(rf_wr_addr_o), 320'd9);
    chk("rstmid_pt_en", 320'(rf_wr_en_o), 320'd2);
    chk("rstmid_pt_nointg", 320'(rf_wr_data_no_intg_o), 320'({8{32'h01234567}}));
    chk("rstmid_pt_we", 320'(rf_we_o), 320'h200);
    chk("rstmid_err", 320'(core_wr_err_o), 320'd0);
    core_wr_en_i = 2'b00;
    nack = 0; bad_busy = 1'b0;
    for (int c = 0; c < 70; c++) begin
      tick(); #2;
      if (wipe_ack_o) nack++;
      if (wipe_busy_o) bad_busy = 1'b1;
    end
    chk("rstmid_no_ack", 320'(nack), 320'd0);
    chk("rstmid_stays_idle", 320'(bad_busy), 320'd0);

    // Request held high: no restart mid-wipe, second wipe one cycle after DONE.
    tick();
    run_wipe("hold", 0, 1'b1, 1'b0);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Global time bound so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/otbn_rf_bignum_wipe_ctrl.md
# otbn_rf_bignum_wipe_ctrl

Write-port sequencer and arbiter for the bignum WDR register file. It sits between the OTBN core and the WDR file. In normal operation it passes the core's write port, and the matching one-hot predecoded write enable, straight through. On a wipe request it takes the write port and overwrites all WDRs twice: first with URND data, then with the integrity-valid zero word. It signals completion to the start/stop control.

## Interface
Parameters:
- `NWdr`, 32, number of WDRs; must be a power of two.
- `WdrAw`, `$clog2(NWdr)`, WDR address width.

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  synchronous, active-high reset.
- `wipe_req_i`  in  1  start wipe; sampled in IDLE only.
- `wipe_busy_o`  out  1  high in any state except IDLE.
- `wipe_ack_o`  out  1  one-cycle completion pulse.
- `urnd_valid_i`  in  1  URND word available.
- `urnd_data_i`  in  WLEN  URND word.
- `urnd_ack_o`  out  1  URND word consumed this cycle.
- `core_wr_addr_i`, `core_wr_en_i`[2], `core_wr_commit_i`, `core_wr_data_no_intg_i`[WLEN], `core_wr_data_intg_i`[ExtWLEN], `core_wr_data_intg_sel_i`, `core_rf_we_i`[NWdr]  in  core write port and its predecoded write enable.
- `rf_wr_addr_o`, `rf_wr_en_o`, `rf_wr_commit_o`, `rf_wr_data_no_intg_o`, `rf_wr_data_intg_o`, `rf_wr_data_intg_sel_o`, `rf_we_o`  out  same widths; drive the register file and its predecode input.
- `core_wr_err_o`  out  1  core attempted a write while the wipe was busy.

## Operation
- Reset: state IDLE, counter 0. All `rf_*` outputs follow the core inputs. `wipe_busy_o`, `wipe_ack_o`, `urnd_ack_o` and `core_wr_err_o` are all 0.
- **IDLE**:
  - `rf_*` = `core_*` combinationally; `rf_we_o` = `core_rf_we_i`.
  - On `wipe_req_i`: go to RND and set counter to 0.
- **RND**:
  - When `urnd_valid_i` is high: `rf_wr_addr_o` = counter, `rf_wr_en_o` = 2'b11, `rf_wr_commit_o` = 1, `rf_wr_data_intg_sel_o` = 0, `rf_wr_data_no_intg_o` = `urnd_data_i`, `urnd_ack_o` = 1, `rf_we_o` = onehot(counter). Counter increments.
  - When `urnd_valid_i` is low: `rf_wr_en_o` = 0, `rf_wr_commit_o` = 0, `rf_we_o` = 0, `urnd_ack_o` = 0. Counter holds.
  - A write at counter = NWdr-1 wraps the counter to 0 and moves to ZERO.
- **ZERO**:
  - Writes every cycle with no stall: `rf_wr_data_intg_sel_o` = 1, `rf_wr_data_intg_o` = `SecdedInv3932ZeroWord` replicated `BaseWordsPerWLEN` times, `rf_wr_en_o` = 2'b11, `rf_wr_commit_o` = 1, `rf_we_o` = onehot(counter).
  - A write at counter = NWdr-1 moves to DONE.
- **DONE**: `wipe_ack_o` = 1 for exactly one cycle, no write, then IDLE.
- **Outside IDLE**:
  - Core inputs are ignored.
  - `core_wr_err_o` = `|core_wr_en_i` (combinational level).
  - Unused data outputs are driven to 0; core data never reaches the RF while busy.
  - `wipe_req_i` is ignored.
- Reset at any point returns to IDLE and counter 0. No ack is generated for a wipe cut short by reset.
- Unused data fields are always 0: `rf_wr_data_intg_o` in RND and `rf_wr_data_no_intg_o` in ZERO.

## Timing
- FSM state and counter are registered; all outputs are combinational from state, counter and inputs.
- Latency with URND always valid:
  - `wipe_req_i` high at edge 0 puts the block in RND for cycles 1..NWdr.
  - ZERO runs for cycles NWdr+1..2·NWdr.
  - `wipe_ack_o` is high in cycle 2·NWdr+1, i.e. cycle 65 for NWdr = 32.
- Each low cycle of `urnd_valid_i` during RND adds one cycle of latency.
- `wipe_req_i` in the DONE cycle is ignored. A request in the following IDLE cycle starts a new wipe, so the back-to-back gap is 1 cycle.
- Passthrough in IDLE adds zero latency.

## Structure
- `otbn_pkg` gains the typedef `otbn_wipe_state_e` (IDLE, RND, ZERO, DONE), sparse-encoded for fault hardening.
- `otbn_pkg` already provides `WLEN`, `ExtWLEN`, `NWdr`, `WdrAw` and `BaseWordsPerWLEN`.
- The zero word comes from `prim_secded_pkg::SecdedInv3932ZeroWord`.
- One sub-module: `prim_onehot_enc` (OneHotWidth = NWdr) generates `rf_we_o` from the counter, enabled by the write qualifier.
- The counter is WdrAw bits wide and wraps naturally.

## Test plan
- **Passthrough:** in IDLE, core writes addr 5, en 2'b01, commit 1 -> identical `rf_*` outputs in the same cycle; `rf_we_o` = `core_rf_we_i`; `core_wr_err_o` = 0.
- **Full wipe:** `urnd_valid_i` tied high, `wipe_req_i` pulsed at cycle 0.
  - RND writes addr 0..31 with `urnd_data_i` and sel 0.
  - ZERO writes addr 0..31 with sel 1 and the zero word.
  - `wipe_ack_o` is high only in cycle 65; `wipe_busy_o` is high in cycles 1..65.
  - A scoreboard confirms every read returns the zero word and the RF integrity check passes.
- **URND stall:** drop `urnd_valid_i` for 3 cycles at counter 10 -> no write and no ack for those cycles, counter holds at 10, `wipe_ack_o` arrives at cycle 68.
- **Core interference:** core asserts `core_wr_en_i` = 2'b11 during ZERO -> `core_wr_err_o` = 1 in that cycle; the RF sees only wipe writes.
- **Reset mid-wipe:** assert `rst_i` at counter 20 of RND -> next cycle is IDLE with `wipe_busy_o` = 0 and passthrough restored; no `wipe_ack_o`.
- **Repeated request:** `wipe_req_i` held high throughout -> no restart during the wipe; a second wipe begins the cycle after DONE.
